// File: rtl/wb_regfile.sv
// ============================================================================
// Module   : wb_regfile
// Brief    : Write-back select plus 32x32 register file with write-through
//            read bypass and a committed-write counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] ddpc4,
  input  logic [DW-1:0] dbusw,
  input  logic [DW-1:0] ddata,
  input  logic [AW-1:0] drw,
  input  logic          nnnreg_write,
  input  logic [1:0]    nnns_data_write,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [DW-1:0] busa,
  output logic [DW-1:0] busb,
  output logic [DW-1:0] wb_data,
  output logic          wb_valid,
  output logic [CW-1:0] wb_count
);

  localparam int c_NREG = 1 << AW;

  localparam logic [1:0] c_SEL_ALU  = 2'b00;
  localparam logic [1:0] c_SEL_LOAD = 2'b01;
  localparam logic [1:0] c_SEL_LINK = 2'b10;
  localparam logic [1:0] c_SEL_RSVD = 2'b11;

  logic [DW-1:0] r_regs [c_NREG];
  logic [CW-1:0] r_count;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic [DW-1:0] w_busa;
  logic [DW-1:0] w_busb;

  // Reserved and unknown selects collapse to zero so nothing undefined reaches the array.
  always_comb begin
    w_data = '0;
    case (nnns_data_write)
      c_SEL_ALU:  w_data = dbusw;
      c_SEL_LOAD: w_data = ddata;
      c_SEL_LINK: w_data = ddpc4;
      default:    w_data = '0;
    endcase
  end

  assign w_valid = nnnreg_write && (drw != '0) && (nnns_data_write != c_SEL_RSVD);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_count <= '0;
    end else if (w_valid) begin
      r_regs[drw] <= w_data;
      r_count     <= r_count + CW'(1);
    end
  end

  // Same-cycle bypass replaces a write-first/read-second register file.
  always_comb begin
    w_busa = '0;
    if (ra != '0) begin
      if (w_valid && (ra == drw)) w_busa = w_data;
      else                        w_busa = r_regs[ra];
    end
  end

  always_comb begin
    w_busb = '0;
    if (rb != '0) begin
      if (w_valid && (rb == drw)) w_busb = w_data;
      else                        w_busb = r_regs[rb];
    end
  end

  assign busa     = w_busa;
  assign busb     = w_busb;
  assign wb_data  = w_data;
  assign wb_valid = w_valid;
  assign wb_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Directed self-checking bench for wb_regfile (32-bit and 4-bit
//            counter instances sharing one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;

  logic        clock;
  logic        reset;
  logic [31:0] ddpc4, dbusw, ddata;
  logic [4:0]  drw, ra, rb;
  logic        nnnreg_write;
  logic [1:0]  nnns_data_write;

  logic [31:0] busa, busb, wb_data, wb_count;
  logic        wb_valid;
  logic [31:0] s_busa, s_busb, s_wb_data;
  logic        s_wb_valid;
  logic [3:0]  s_wb_count;

  int total = 0;
  int bad   = 0;

  wb_regfile #(.DW(32), .AW(5), .CW(32)) u_dut (
    .clock(clock), .reset(reset), .ddpc4(ddpc4), .dbusw(dbusw), .ddata(ddata),
    .drw(drw), .nnnreg_write(nnnreg_write), .nnns_data_write(nnns_data_write),
    .ra(ra), .rb(rb), .busa(busa), .busb(busb), .wb_data(wb_data),
    .wb_valid(wb_valid), .wb_count(wb_count)
  );

  // Small counter width so the wrap is reachable in a few cycles.
  wb_regfile #(.DW(32), .AW(5), .CW(4)) u_small (
    .clock(clock), .reset(reset), .ddpc4(ddpc4), .dbusw(dbusw), .ddata(ddata),
    .drw(drw), .nnnreg_write(nnnreg_write), .nnns_data_write(nnns_data_write),
    .ra(ra), .rb(rb), .busa(s_busa), .busb(s_busb), .wb_data(s_wb_data),
    .wb_valid(s_wb_valid), .wb_count(s_wb_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Puts the value on the selected source bus and distinct junk on the others.
  task automatic set_wr(input logic we, input logic [1:0] sel, input logic [4:0] rd,
                        input logic [31:0] val);
    nnnreg_write    = we;
    nnns_data_write = sel;
    drw             = rd;
    dbusw           = 32'h1111_0000;
    ddata           = 32'h2222_0000;
    ddpc4           = 32'h3333_0000;
    case (sel)
      2'b00:   dbusw = val;
      2'b01:   ddata = val;
      2'b10:   ddpc4 = val;
      default: dbusw = val;
    endcase
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    ra    = '0;
    rb    = '0;
    set_wr(1'b0, 2'b00, 5'd0, 32'h0);

    // Reset state: every address reads zero on both ports
    #1;
    chk("reset_count", wb_count, 32'd0);
    chk("reset_s_count", {28'd0, s_wb_count}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i);
      rb = 5'(31 - i);
      #1;
      chk("reset_busa", busa, 32'd0);
      chk("reset_busb", busb, 32'd0);
    end

    @(negedge clock);
    reset = 1'b1;

    // Select paths
    set_wr(1'b1, 2'b00, 5'd5, 32'h0000_1234);
    #1;
    chk("sel00_valid", {31'd0, wb_valid}, 32'd1);
    chk("sel00_data", wb_data, 32'h0000_1234);
    tick;
    set_wr(1'b1, 2'b01, 5'd6, 32'hDEAD_BEEF);
    #1;
    chk("sel01_data", wb_data, 32'hDEAD_BEEF);
    tick;
    set_wr(1'b1, 2'b10, 5'd31, 32'h0040_0008);
    #1;
    chk("sel10_data", wb_data, 32'h0040_0008);
    tick;
    set_wr(1'b0, 2'b00, 5'd0, 32'h0);
    ra = 5'd5;
    rb = 5'd6;
    #1;
    chk("read_r5", busa, 32'h0000_1234);
    chk("read_r6", busb, 32'hDEAD_BEEF);
    ra = 5'd31;
    #1;
    chk("read_r31", busa, 32'h0040_0008);
    chk("count_after_sel", wb_count, 32'd3);

    // Preload r7/r8 so suppressed writes are observable
    set_wr(1'b1, 2'b00, 5'd7, 32'h0000_0077);
    tick;
    set_wr(1'b1, 2'b00, 5'd8, 32'h0000_0088);
    tick;

    // Suppression: r0 target, reserved select, write disabled
    set_wr(1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF);
    ra = 5'd0;
    rb = 5'd0;
    #1;
    chk("r0_valid", {31'd0, wb_valid}, 32'd0);
    chk("r0_busa", busa, 32'd0);
    chk("r0_busb", busb, 32'd0);
    tick;
    set_wr(1'b1, 2'b11, 5'd7, 32'hCAFE_F00D);
    ra = 5'd7;
    #1;
    chk("sel11_valid", {31'd0, wb_valid}, 32'd0);
    chk("sel11_data", wb_data, 32'd0);
    chk("sel11_nobypass", busa, 32'h0000_0077);
    tick;
    set_wr(1'b0, 2'b00, 5'd8, 32'h0000_0BAD);
    ra = 5'd8;
    #1;
    chk("we0_valid", {31'd0, wb_valid}, 32'd0);
    chk("we0_nobypass", busa, 32'h0000_0088);
    tick;
    set_wr(1'b0, 2'b00, 5'd0, 32'h0);
    ra = 5'd7;
    rb = 5'd8;
    #1;
    chk("r7_kept", busa, 32'h0000_0077);
    chk("r8_kept", busb, 32'h0000_0088);
    ra = 5'd0;
    #1;
    chk("r0_zero", busa, 32'd0);
    chk("count_after_supp", wb_count, 32'd5);

    // Bypass on both ports
    ra = 5'd9;
    rb = 5'd9;
    #1;
    chk("r9_before", busa, 32'd0);
    set_wr(1'b1, 2'b00, 5'd9, 32'hA5A5_A5A5);
    #1;
    chk("bypass_a", busa, 32'hA5A5_A5A5);
    chk("bypass_b", busb, 32'hA5A5_A5A5);
    tick;
    set_wr(1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    chk("r9_stored", busa, 32'hA5A5_A5A5);
    chk("count_after_bypass", wb_count, 32'd6);

    // Back-to-back writes to the same register
    ra = 5'd3;
    rb = 5'd3;
    for (int v = 1; v <= 3; v++) begin
      set_wr(1'b1, 2'b00, 5'd3, 32'(v));
      #1;
      chk("b2b_bypass", busa, 32'(v));
      tick;
    end
    set_wr(1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    chk("b2b_final_a", busa, 32'd3);
    chk("b2b_final_b", busb, 32'd3);
    chk("count_after_b2b", wb_count, 32'd9);
    chk("s_count_after_b2b", {28'd0, s_wb_count}, 32'd9);

    // Asynchronous reset mid-run with a write pending
    set_wr(1'b1, 2'b00, 5'd10, 32'h0000_00AA);
    ra = 5'd5;
    rb = 5'd31;
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_busa", busa, 32'd0);
    chk("async_rst_busb", busb, 32'd0);
    chk("async_rst_count", wb_count, 32'd0);
    tick;
    set_wr(1'b0, 2'b00, 5'd0, 32'h0);
    ra = 5'd10;
    #1;
    chk("pending_lost", busa, 32'd0);
    reset = 1'b1;

    // Counter wrap on the 4-bit instance
    tick;
    for (int i = 1; i <= 15; i++) begin
      set_wr(1'b1, 2'b00, 5'(i), 32'(i));
      tick;
    end
    set_wr(1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    chk("s_count_15", {28'd0, s_wb_count}, 32'd15);
    chk("count_15", wb_count, 32'd15);
    set_wr(1'b1, 2'b00, 5'd16, 32'h0000_0016);
    tick;
    set_wr(1'b0, 2'b00, 5'd0, 32'h0);
    ra = 5'd15;
    rb = 5'd16;
    #1;
    chk("s_count_wrap", {28'd0, s_wb_count}, 32'd0);
    chk("count_16", wb_count, 32'd16);
    chk("r15_value", busa, 32'd15);
    chk("r16_value", busb, 32'h0000_0016);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
